pattern_sequencer: RTL and testbench

Playback controller for the 8-entry pattern buffer bank (8 buffers x 27 bytes). Drives bufselect/bufp to step through a programmed range of buffers, byte by byte, paced by step_en. Repeats the range a programmed number of times. Stalls at buffer boundaries while the serial loader is writing the buffer about to be entered.

---
 rtl/pattern_pkg.sv | 23 ++
 rtl/pattern_addr_gen.sv | 68 ++++++
 rtl/pattern_sequencer.sv | 111 +++++++++++
 tb/tb_pattern_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared constants and state type for the pattern buffer bank and its playback sequencer.
package pattern_pkg;

   localparam int NOBUFS  = 8;
   localparam int BUFSIZE = 27;
   localparam int SELW    = 3;
   localparam int PTRW    = 5;
   localparam int LOOPW   = 8;
   localparam int MAXPTR  = BUFSIZE - 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      WAIT_LOAD,
      DONE
   } state_t;

   // Byte indices beyond the end of a buffer are pulled back to the last byte.
   function automatic logic [PTRW-1:0] clamp_ptr(input logic [PTRW-1:0] p);
      return (p > PTRW'(MAXPTR)) ? PTRW'(MAXPTR) : p;
   endfunction

endpackage

// File: rtl/pattern_addr_gen.sv
// Buffer/byte address generator: holds the captured range, the play position and the loop count.
module pattern_addr_gen
   import pattern_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             capture,
   input  logic             advance,
   input  logic [SELW-1:0]  start_buf,
   input  logic [SELW-1:0]  end_buf,
   input  logic [PTRW-1:0]  last_ptr,
   input  logic [LOOPW-1:0] loops,
   output logic [SELW-1:0]  bufselect,
   output logic [PTRW-1:0]  bufp,
   output logic [SELW-1:0]  next_sel,
   output logic             last_byte,
   output logic             last_buf,
   output logic             last_loop
);

   logic [SELW-1:0]  start_r;
   logic [SELW-1:0]  end_r;
   logic [PTRW-1:0]  last_ptr_r;
   logic [LOOPW-1:0] loops_r;
   logic [LOOPW-1:0] loop_cnt;
   logic [LOOPW-1:0] loop_inc;

   assign loop_inc  = loop_cnt + LOOPW'(1);
   assign last_byte = (bufp >= last_ptr_r);
   assign last_buf  = (bufselect == end_r);
   // loops_r == 0 means endless playback: the count is never compared.
   assign last_loop = (loops_r != '0) && (loop_inc == loops_r);
   assign next_sel  = last_buf ? start_r : bufselect + SELW'(1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         start_r    <= '0;
         end_r      <= '0;
         last_ptr_r <= '0;
         loops_r    <= '0;
         loop_cnt   <= '0;
         bufselect  <= '0;
         bufp       <= '0;
      end else if (capture) begin
         start_r    <= start_buf;
         end_r      <= end_buf;
         last_ptr_r <= clamp_ptr(last_ptr);
         loops_r    <= loops;
         loop_cnt   <= '0;
         bufselect  <= start_buf;
         bufp       <= '0;
      end else if (advance) begin
         if (!last_byte) begin
            bufp <= bufp + PTRW'(1);
         end else begin
            bufp <= '0;
            if (last_buf && loop_cnt != '1) begin
               loop_cnt <= loop_inc;
            end
            // On the final byte of the final pass the last buffer stays selected.
            if (!(last_buf && last_loop)) begin
               bufselect <= next_sel;
            end
         end
      end
   end

endmodule

// File: rtl/pattern_sequencer.sv
// Playback controller stepping through a range of pattern buffers, stalling on loader conflicts.
module pattern_sequencer
   import pattern_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             stop,
   input  logic [SELW-1:0]  start_buf,
   input  logic [SELW-1:0]  end_buf,
   input  logic [PTRW-1:0]  last_ptr,
   input  logic [LOOPW-1:0] loops,
   input  logic             step_en,
   input  logic             load_active,
   input  logic [SELW-1:0]  load_addr,
   output logic [SELW-1:0]  bufselect,
   output logic [PTRW-1:0]  bufp,
   output logic             byte_valid,
   output logic             busy,
   output logic             done,
   output logic             load_conflict
);

   state_t          state;
   state_t          state_nxt;
   logic            capture;
   logic            advance;
   logic            finish;
   logic            buf_change;
   logic            enter_busy;
   logic            hold_busy;
   logic            conflict;
   logic            conflict_q;
   logic [SELW-1:0] next_sel;
   logic            last_byte;
   logic            last_buf;
   logic            last_loop;

   assign capture    = (state == IDLE) && start && !stop;
   assign advance    = (state == RUN) && step_en && !stop;
   assign finish     = advance && last_byte && last_buf && last_loop;
   assign buf_change = advance && last_byte && !(last_buf && last_loop);
   assign enter_busy = load_active && (load_addr == next_sel);
   assign hold_busy  = load_active && (load_addr == bufselect);
   // Loader touching the buffer while bytes of it have already been played.
   assign conflict   = (state == RUN) && hold_busy && (bufp != '0);

   pattern_addr_gen u_addr_gen (
      .clk       (clk),
      .resetn    (resetn),
      .capture   (capture),
      .advance   (advance),
      .start_buf (start_buf),
      .end_buf   (end_buf),
      .last_ptr  (last_ptr),
      .loops     (loops),
      .bufselect (bufselect),
      .bufp      (bufp),
      .next_sel  (next_sel),
      .last_byte (last_byte),
      .last_buf  (last_buf),
      .last_loop (last_loop)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         conflict_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         conflict_q <= conflict;
      end
   end

   always_comb begin
      state_nxt = state;
      if (stop) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_nxt = (load_active && load_addr == start_buf) ? WAIT_LOAD : RUN;
               end
            end
            RUN: begin
               if (finish) begin
                  state_nxt = DONE;
               end else if (buf_change && enter_busy) begin
                  state_nxt = WAIT_LOAD;
               end
            end
            WAIT_LOAD: begin
               if (!hold_busy) begin
                  state_nxt = RUN;
               end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      byte_valid    = (state == RUN) && step_en && !stop;
      busy          = (state != IDLE);
      done          = (state == DONE) && !stop;
      load_conflict = conflict && !conflict_q;
   end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: table vectors, directed corner cases and a randomized run against a position-based model.
module tb_pattern_sequencer;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start, stop, step_en, load_active;
   logic [2:0] start_buf, end_buf, load_addr;
   logic [4:0] last_ptr;
   logic [7:0] loops;
   logic [2:0] bufselect;
   logic [4:0] bufp;
   logic       byte_valid, busy, done, load_conflict;

   pattern_sequencer dut (
      .clk           (clk),
      .resetn        (resetn),
      .start         (start),
      .stop          (stop),
      .start_buf     (start_buf),
      .end_buf       (end_buf),
      .last_ptr      (last_ptr),
      .loops         (loops),
      .step_en       (step_en),
      .load_active   (load_active),
      .load_addr     (load_addr),
      .bufselect     (bufselect),
      .bufp          (bufp),
      .byte_valid    (byte_valid),
      .busy          (busy),
      .done          (done),
      .load_conflict (load_conflict)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit step;
      bit la;
      int laddr;
      int ebuf;
      int eptr;
      bit ebv;
      bit ebusy;
      bit edone;
   } vec_t;

   vec_t tbl1[$];
   vec_t tbl4[$];

   // Model: play position is an index into the flattened range of (buffer, byte) pairs.
   int m_mode;   // 0 idle, 1 run, 2 wait for loader, 3 done
   int m_sb, m_lp, m_loops, m_len, m_pos, m_pass, m_buf, m_ptr;
   bit m_prev;

   int s_buf, s_ptr;
   bit s_bv, s_busy, s_done;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_cond();
      return (m_mode == 1) && load_active && (int'(load_addr) == m_buf) && (m_ptr != 0);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_sb = 0; m_lp = 0; m_loops = 0; m_len = 1;
      m_pos = 0; m_pass = 0; m_buf = 0; m_ptr = 0; m_prev = 0;
   endtask

   task automatic model_step();
      bit c;
      c = model_cond();
      if (stop) begin
         m_mode = 0;
      end else begin
         case (m_mode)
            0: if (start) begin
               m_sb    = int'(start_buf);
               m_lp    = (int'(last_ptr) > 26) ? 26 : int'(last_ptr);
               m_loops = int'(loops);
               m_len   = ((int'(end_buf) - m_sb + 8) % 8 + 1) * (m_lp + 1);
               m_pos = 0; m_pass = 0; m_buf = m_sb; m_ptr = 0;
               m_mode = (load_active && int'(load_addr) == m_sb) ? 2 : 1;
            end
            1: if (step_en) begin
               m_pos++;
               if (m_pos == m_len) begin
                  m_pos = 0;
                  m_pass++;
               end
               if (m_loops != 0 && m_pass == m_loops) begin
                  m_ptr  = 0;
                  m_mode = 3;
               end else begin
                  m_buf = (m_sb + m_pos / (m_lp + 1)) % 8;
                  m_ptr = m_pos % (m_lp + 1);
                  if (m_ptr == 0 && load_active && int'(load_addr) == m_buf) m_mode = 2;
               end
            end
            2: if (!(load_active && int'(load_addr) == m_buf)) m_mode = 1;
            default: m_mode = 0;
         endcase
      end
      m_prev = c;
   endtask

   task automatic sample();
      s_buf = int'(bufselect); s_ptr = int'(bufp);
      s_bv = byte_valid; s_busy = busy; s_done = done;
   endtask

   task automatic check_model();
      chk("bufselect", int'(bufselect), m_buf);
      chk("bufp", int'(bufp), m_ptr);
      chk("byte_valid", int'(byte_valid), int'(m_mode == 1 && step_en && !stop));
      chk("busy", int'(busy), int'(m_mode != 0));
      chk("done", int'(done), int'(m_mode == 3 && !stop));
      chk("load_conflict", int'(load_conflict), int'(model_cond() && !m_prev));
   endtask

   task automatic tick();
      #2;
      sample();
      check_model();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic tick_tbl(input vec_t v, input string tag);
      step_en = v.step; load_active = v.la; load_addr = 3'(v.laddr);
      #2;
      chk({tag, " bufselect"}, int'(bufselect), v.ebuf);
      chk({tag, " bufp"}, int'(bufp), v.eptr);
      chk({tag, " byte_valid"}, int'(byte_valid), int'(v.ebv));
      chk({tag, " busy"}, int'(busy), int'(v.ebusy));
      chk({tag, " done"}, int'(done), int'(v.edone));
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic configure(input int sb, input int eb, input int lp, input int lo);
      start_buf = 3'(sb); end_buf = 3'(eb); last_ptr = 5'(lp); loops = 8'(lo);
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic stop_idle();
      stop = 1'b1; tick(); stop = 1'b0; tick();
   endtask

   task automatic do_reset();
      #3 resetn = 1'b0;
      #1;
      model_reset();
      chk("reset bufselect", int'(bufselect), 0);
      chk("reset bufp", int'(bufp), 0);
      chk("reset byte_valid", int'(byte_valid), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset load_conflict", int'(load_conflict), 0);
      #2 resetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int q[$];
      int exp2[8];
      int maxp, wraps, dcnt;

      for (int p = 0; p < 4; p++) tbl1.push_back('{1, 0, 0, 2, p, 1, 1, 0});
      for (int p = 0; p < 4; p++) tbl1.push_back('{1, 0, 0, 3, p, 1, 1, 0});
      tbl1.push_back('{1, 0, 0, 3, 0, 0, 1, 1});
      tbl1.push_back('{1, 0, 0, 3, 0, 0, 0, 0});

      tbl4.push_back('{1, 0, 0, 0, 0, 1, 1, 0});
      tbl4.push_back('{1, 0, 0, 0, 1, 1, 1, 0});
      tbl4.push_back('{1, 1, 1, 0, 2, 1, 1, 0});
      for (int i = 0; i < 4; i++) tbl4.push_back('{1, 1, 1, 1, 0, 0, 1, 0});
      tbl4.push_back('{1, 0, 0, 1, 0, 0, 1, 0});
      tbl4.push_back('{1, 0, 0, 1, 0, 1, 1, 0});
      tbl4.push_back('{1, 0, 0, 1, 1, 1, 1, 0});

      exp2 = '{6, 7, 0, 1, 6, 7, 0, 1};

      resetn = 1'b0; start = 0; stop = 0; step_en = 0; load_active = 0; load_addr = 0;
      configure(0, 0, 0, 0);
      model_reset();
      #3;
      chk("por bufselect", int'(bufselect), 0);
      chk("por busy", int'(busy), 0);
      chk("por byte_valid", int'(byte_valid), 0);
      #9 resetn = 1'b1;
      @(posedge clk);
      #1;

      // Two buffers of four bytes, single pass.
      configure(2, 3, 3, 1);
      step_en = 1'b1;
      pulse_start();
      foreach (tbl1[i]) tick_tbl(tbl1[i], "t1");

      // Range wrapping 7->0, one byte per buffer, two passes.
      configure(6, 1, 0, 2);
      pulse_start();
      q = {};
      for (int i = 0; i < 12; i++) begin
         tick();
         if (s_bv) q.push_back(s_buf);
         if (s_done) break;
      end
      chk("t2 done seen", int'(s_done), 1);
      chk("t2 steps", q.size(), 8);
      for (int i = 0; i < 8 && i < q.size(); i++) chk("t2 bufselect seq", q[i], exp2[i]);
      tick();

      // Out-of-range last_ptr clamps to the final byte.
      configure(5, 5, 31, 0);
      pulse_start();
      maxp = 0; wraps = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (s_bv && s_ptr > maxp) maxp = s_ptr;
         if (s_bv && s_ptr == 26) wraps++;
      end
      chk("t3 max bufp", maxp, 26);
      chk("t3 reached last byte twice", wraps, 2);
      stop_idle();

      // Loader busy on the next buffer across the boundary.
      configure(0, 1, 2, 0);
      step_en = 1'b1; load_active = 1'b0;
      pulse_start();
      foreach (tbl4[i]) tick_tbl(tbl4[i], "t4");
      load_active = 1'b0;
      stop_idle();

      // Abort mid-buffer, then start together with stop.
      configure(1, 2, 5, 1);
      pulse_start();
      for (int i = 0; i < 3; i++) tick();
      stop = 1'b1; tick();
      chk("t5 byte_valid on stop", int'(s_bv), 0);
      chk("t5 no done on stop", int'(s_done), 0);
      stop = 1'b0; tick();
      chk("t5 idle after stop", int'(s_busy), 0);
      chk("t5 bufp held", s_ptr, 3);
      start = 1'b1; stop = 1'b1; tick();
      start = 1'b0; stop = 1'b0; tick();
      chk("t5 start+stop stays idle", int'(s_busy), 0);

      // Endless mode well beyond the loop counter range, then async reset mid-run.
      configure(4, 4, 0, 0);
      pulse_start();
      dcnt = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (s_done) dcnt++;
      end
      chk("t6 no done in endless mode", dcnt, 0);
      chk("t6 still busy", int'(s_busy), 1);
      do_reset();

      // Randomized playback, loader traffic, aborts and restarts.
      for (int r = 0; r < 25; r++) begin
         configure($urandom_range(0, 7), $urandom_range(0, 7),
                   ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3),
                   $urandom_range(0, 3));
         pulse_start();
         for (int i = 0; i < 120; i++) begin
            step_en     = ($urandom_range(0, 9) < 7);
            load_active = ($urandom_range(0, 9) < 3);
            load_addr   = 3'($urandom_range(0, 7));
            stop        = ($urandom_range(0, 99) == 0);
            start       = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0)
               configure($urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 4), $urandom_range(0, 3));
            tick();
         end
         start = 1'b0; load_active = 1'b0;
         stop_idle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
